marx_credit_arbiter: RTL and testbench

// - Round-robin, credit-limited allocator. Shares NOUT pipelined APUs of one type between NIN CPUs.
// - Drop-in alternative to the plain marx arbiter: same req/ack/avail/alloc/assid contract.
// - Adds a per-CPU cap on in-flight ops, so one CPU cannot fill a pipelined APU and starve its peers.
// - Sits in marx between the CPU request lines and the APU valid/tag muxing.

---
 rtl/apu_cluster_package.sv | 31 +++
 rtl/marx_rr_pick.sv | 29 ++
 rtl/marx_credit_arbiter.sv | 108 ++++++++++
 tb/tb_marx_credit_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/apu_cluster_package.sv
// Shared definitions for the marx APU arbiters: defaults and a rotated find-first-set helper.
package apu_cluster_package;

  localparam int unsigned MARX_DEFAULT_MAXOUT = 2;
  localparam int unsigned MARX_MAX_NIN        = 32;
  localparam int unsigned MARX_IDX_W          = 5;

  typedef struct packed {
    logic                  found;
    logic [MARX_IDX_W-1:0] idx;
  } marx_pick_t;

  // Scan ptr, ptr+1, ... mod n and return the first set bit of mask.
  function automatic marx_pick_t marx_rr_first(input logic [MARX_MAX_NIN-1:0] mask,
                                               input int unsigned ptr,
                                               input int unsigned n);
    marx_pick_t  res;
    int unsigned idx;
    res = '0;
    for (int unsigned j = 0; j < MARX_MAX_NIN; j++) begin
      idx = ptr + j;
      if (idx >= n) idx = idx - n;
      if ((j < n) && !res.found && mask[idx[MARX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[MARX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/marx_rr_pick.sv
// One stage of the grant chain: picks one requester for one resource, rotating from i_ptr.
module marx_rr_pick
  import apu_cluster_package::*;
#(
  parameter int unsigned NIN = 4,
  parameter int unsigned WID = 2
) (
  input  logic [NIN-1:0] i_mask,
  input  logic           i_en,
  input  logic [WID-1:0] i_ptr,
  output logic           o_valid,
  output logic [WID-1:0] o_idx,
  output logic [NIN-1:0] o_onehot
);

  logic [MARX_MAX_NIN-1:0] w_mask_ext;
  marx_pick_t              w_pick;

  always_comb begin
    w_mask_ext            = '0;
    w_mask_ext[NIN-1:0]   = i_mask;
    w_pick                = marx_rr_first(w_mask_ext, 32'(i_ptr), NIN);
    o_valid               = i_en & w_pick.found;
    o_idx                 = WID'(w_pick.idx);
    o_onehot              = '0;
    if (o_valid) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/marx_credit_arbiter.sv
// Round-robin APU allocator with a per-CPU cap on in-flight operations.
module marx_credit_arbiter
  import apu_cluster_package::*;
#(
  parameter int unsigned NIN    = 4,
  parameter int unsigned NOUT   = 1,
  parameter int unsigned MAXOUT = MARX_DEFAULT_MAXOUT,
  localparam int unsigned WID   = (NIN > 1) ? $clog2(NIN) : 1,
  localparam int unsigned WCNT  = $clog2(MAXOUT + 1)
) (
  input  logic                  clk_ci,
  input  logic                  rst_ri,
  input  logic [NIN-1:0]        req_d,
  output logic [NIN-1:0]        ack_d,
  input  logic [NOUT-1:0]       avail_d,
  output logic [NOUT-1:0]       alloc_d,
  output logic [NOUT*WID-1:0]   assid_d,
  input  logic [NIN-1:0]        retire_d,
  output logic [NIN*WCNT-1:0]   credit_d,
  output logic                  err_o
);

  logic [WID-1:0]             r_ptr;
  logic [WCNT-1:0]            r_cnt [NIN];
  logic                       r_err;

  logic [NIN-1:0]             w_elig;
  logic [NOUT:0][NIN-1:0]     w_taken;
  logic [NOUT-1:0][NIN-1:0]   w_onehot;
  logic [NOUT-1:0][WID-1:0]   w_idx;
  logic [NOUT-1:0]            w_valid;
  logic [WID-1:0]             w_last;
  logic [WID-1:0]             w_ptr_nxt;
  logic                       w_any;
  logic [WCNT-1:0]            w_cnt_nxt [NIN];
  logic                       w_underflow;

  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      w_elig[i] = req_d[i] & (r_cnt[i] < WCNT'(MAXOUT));
    end
  end

  // Each stage sees only requesters not already granted by a lower-k resource.
  assign w_taken[0] = '0;

  for (genvar k = 0; k < NOUT; k++) begin : g_chain
    marx_rr_pick #(
      .NIN (NIN),
      .WID (WID)
    ) u_pick (
      .i_mask   (w_elig & ~w_taken[k]),
      .i_en     (avail_d[k]),
      .i_ptr    (r_ptr),
      .o_valid  (w_valid[k]),
      .o_idx    (w_idx[k]),
      .o_onehot (w_onehot[k])
    );
    assign w_taken[k+1] = w_taken[k] | w_onehot[k];
  end

  always_comb begin
    ack_d   = rst_ri ? '0 : w_taken[NOUT];
    alloc_d = rst_ri ? '0 : w_valid;
    assid_d = '0;
    for (int k = 0; k < NOUT; k++) begin
      if (!rst_ri && w_valid[k]) assid_d[k*WID +: WID] = w_idx[k];
    end
    err_o = r_err & ~rst_ri;
  end

  always_comb begin
    w_any  = |w_valid;
    w_last = '0;
    for (int k = 0; k < NOUT; k++) begin
      if (w_valid[k]) w_last = w_idx[k];
    end
    w_ptr_nxt = (w_last == WID'(NIN - 1)) ? '0 : w_last + 1'b1;
  end

  always_comb begin
    w_underflow = 1'b0;
    credit_d    = '0;
    for (int i = 0; i < NIN; i++) begin
      w_cnt_nxt[i]               = r_cnt[i];
      credit_d[i*WCNT +: WCNT]   = r_cnt[i];
      if (retire_d[i] && (r_cnt[i] == '0)) w_underflow = 1'b1;
      if (w_taken[NOUT][i] && !retire_d[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end else if (!w_taken[NOUT][i] && retire_d[i] && (r_cnt[i] != '0)) begin
        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ci) begin
    if (rst_ri) begin
      r_ptr <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < NIN; i++) r_cnt[i] <= '0;
    end else begin
      if (w_any) r_ptr <= w_ptr_nxt;
      if (w_underflow) r_err <= 1'b1;
      for (int i = 0; i < NIN; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_marx_credit_arbiter.sv
// Self-checking bench for marx_credit_arbiter: directed scenarios plus randomized traffic.
module tb_marx_credit_arbiter;

  localparam int NIN    = 4;
  localparam int NOUT   = 2;
  localparam int MAXOUT = 2;
  localparam int WID    = 2;
  localparam int WCNT   = 2;

  logic                clk_ci = 1'b0;
  logic                rst_ri;
  logic [NIN-1:0]      req_d;
  logic [NIN-1:0]      ack_d;
  logic [NOUT-1:0]     avail_d;
  logic [NOUT-1:0]     alloc_d;
  logic [NOUT*WID-1:0] assid_d;
  logic [NIN-1:0]      retire_d;
  logic [NIN*WCNT-1:0] credit_d;
  logic                err_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state: outstanding ops per CPU, next CPU in rotation, sticky error.
  int m_cnt [NIN];
  int m_ptr;
  bit m_err;

  logic [NIN-1:0]      obs_ack;
  logic [NOUT-1:0]     obs_alloc;
  logic [NOUT*WID-1:0] obs_assid;
  logic [NIN*WCNT-1:0] obs_credit;
  logic                obs_err;

  always #5 clk_ci = ~clk_ci;

  marx_credit_arbiter #(
    .NIN    (NIN),
    .NOUT   (NOUT),
    .MAXOUT (MAXOUT)
  ) dut (
    .clk_ci   (clk_ci),
    .rst_ri   (rst_ri),
    .req_d    (req_d),
    .ack_d    (ack_d),
    .avail_d  (avail_d),
    .alloc_d  (alloc_d),
    .assid_d  (assid_d),
    .retire_d (retire_d),
    .credit_d (credit_d),
    .err_o    (err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, compare against the model mid-cycle, then advance the model.
  task automatic cycle(input logic rst, input logic [NIN-1:0] req, input logic [NOUT-1:0] avail,
                       input logic [NIN-1:0] ret);
    logic [NIN-1:0]      e_ack;
    logic [NOUT-1:0]     e_alloc;
    logic [NOUT*WID-1:0] e_assid;
    logic [NIN*WCNT-1:0] e_credit;
    int                  last;
    bit                  any;
    bit                  found;
    int                  cand;
    rst_ri   = rst;
    req_d    = req;
    avail_d  = avail;
    retire_d = ret;
    e_ack = '0; e_alloc = '0; e_assid = '0; any = 0; last = 0;
    if (!rst) begin
      for (int k = 0; k < NOUT; k++) begin
        found = 0;
        if (avail[k]) begin
          for (int j = 0; j < NIN; j++) begin
            cand = (m_ptr + j) % NIN;
            if (!found && req[cand] && (m_cnt[cand] < MAXOUT) && !e_ack[cand]) begin
              found = 1;
              e_ack[cand] = 1'b1;
              e_alloc[k] = 1'b1;
              e_assid[k*WID +: WID] = WID'(cand);
              any = 1;
              last = cand;
            end
          end
        end
      end
    end
    for (int i = 0; i < NIN; i++) e_credit[i*WCNT +: WCNT] = WCNT'(m_cnt[i]);

    @(negedge clk_ci);
    obs_ack = ack_d; obs_alloc = alloc_d; obs_assid = assid_d;
    obs_credit = credit_d; obs_err = err_o;
    check_eq("ack", 32'(obs_ack), 32'(e_ack));
    check_eq("alloc", 32'(obs_alloc), 32'(e_alloc));
    check_eq("assid", 32'(obs_assid), 32'(e_assid));
    check_eq("credit", 32'(obs_credit), 32'(e_credit));
    check_eq("err", 32'(obs_err), 32'(!rst && m_err));

    @(posedge clk_ci);
    if (rst) begin
      for (int i = 0; i < NIN; i++) m_cnt[i] = 0;
      m_ptr = 0;
      m_err = 0;
    end else begin
      if (any) m_ptr = (last + 1) % NIN;
      for (int i = 0; i < NIN; i++) begin
        if (ret[i] && m_cnt[i] == 0) m_err = 1;
        if (e_ack[i] && !ret[i]) m_cnt[i]++;
        else if (!e_ack[i] && ret[i] && m_cnt[i] > 0) m_cnt[i]--;
      end
    end
    #1;
  endtask

  initial begin
    logic [NIN-1:0] r_req, r_ret;
    logic [NOUT-1:0] r_av;
    for (int i = 0; i < NIN; i++) m_cnt[i] = 0;
    m_ptr = 0;
    m_err = 0;
    rst_ri = 1'b1; req_d = '1; avail_d = '1; retire_d = '0;
    @(posedge clk_ci);
    #1;

    // Reset gating, then first grants after release.
    cycle(1, 4'b1111, 2'b11, 4'b0000);
    check_eq("rst_ack", 32'(obs_ack), 32'h0);
    check_eq("rst_alloc", 32'(obs_alloc), 32'h0);
    cycle(1, 4'b1111, 2'b11, 4'b0000);
    cycle(0, 4'b1111, 2'b11, 4'b0000);
    check_eq("rel_ack", 32'(obs_ack), 32'h3);
    check_eq("rel_assid", 32'(obs_assid), 32'h4);
    cycle(0, 4'b1111, 2'b01, 4'b0000);
    check_eq("rel_ptr2", 32'(obs_ack), 32'h4);

    // Rotation with retire on every cycle.
    cycle(1, 4'b0000, 2'b00, 4'b0000);
    for (int j = 0; j < 5; j++) begin
      cycle(0, 4'b1111, 2'b01, 4'b1111);
      check_eq("rot_assid", 32'(obs_assid[WID-1:0]), 32'(j % NIN));
      check_eq("rot_cnt_le1", 32'(obs_credit[((j % NIN) * WCNT) +: WCNT] <= 1), 32'h1);
    end

    // Credit exhaustion and recovery after one retire.
    cycle(1, 4'b0000, 2'b00, 4'b0000);
    cycle(0, 4'b0001, 2'b11, 4'b0000);
    check_eq("ex_ack0", 32'(obs_ack), 32'h1);
    cycle(0, 4'b0001, 2'b11, 4'b0000);
    check_eq("ex_ack1", 32'(obs_ack), 32'h1);
    cycle(0, 4'b0001, 2'b11, 4'b0000);
    check_eq("ex_ack2", 32'(obs_ack), 32'h0);
    check_eq("ex_alloc2", 32'(obs_alloc), 32'h0);
    check_eq("ex_cred2", 32'(obs_credit[1:0]), 32'h2);
    cycle(0, 4'b0001, 2'b11, 4'b0001);
    check_eq("ex_ret_ack", 32'(obs_ack), 32'h0);
    cycle(0, 4'b0001, 2'b11, 4'b0000);
    check_eq("ex_after_ret", 32'(obs_ack), 32'h1);

    // Simultaneous ack and retire on CPU2.
    cycle(1, 4'b0000, 2'b00, 4'b0000);
    cycle(0, 4'b0100, 2'b01, 4'b0000);
    cycle(0, 4'b0100, 2'b01, 4'b0100);
    check_eq("sim_ack", 32'(obs_ack), 32'h4);
    cycle(0, 4'b0000, 2'b00, 4'b0000);
    check_eq("sim_cnt", 32'(obs_credit[5:4]), 32'h1);
    check_eq("sim_err", 32'(obs_err), 32'h0);

    // Underflow on CPU3 sets the sticky error.
    cycle(0, 4'b0000, 2'b00, 4'b1000);
    cycle(0, 4'b0000, 2'b00, 4'b0000);
    check_eq("uf_err", 32'(obs_err), 32'h1);
    check_eq("uf_cnt", 32'(obs_credit[7:6]), 32'h0);
    cycle(0, 4'b0000, 2'b00, 4'b0000);
    check_eq("uf_sticky", 32'(obs_err), 32'h1);

    // Mid-operation reset from cnt=(2,1,0,2), ptr=3.
    cycle(1, 4'b0000, 2'b00, 4'b0000);
    cycle(0, 4'b0001, 2'b01, 4'b0000);
    cycle(0, 4'b0001, 2'b01, 4'b0000);
    cycle(0, 4'b1000, 2'b01, 4'b0000);
    cycle(0, 4'b1000, 2'b01, 4'b0000);
    cycle(0, 4'b0010, 2'b01, 4'b0000);
    cycle(0, 4'b0100, 2'b01, 4'b0000);
    cycle(0, 4'b0000, 2'b00, 4'b0100);
    cycle(0, 4'b0000, 2'b00, 4'b0000);
    check_eq("mid_credit", 32'(obs_credit), 32'h86);
    cycle(1, 4'b0000, 2'b00, 4'b0000);
    cycle(0, 4'b0000, 2'b00, 4'b0000);
    check_eq("mid_cred0", 32'(obs_credit), 32'h0);
    check_eq("mid_err0", 32'(obs_err), 32'h0);
    cycle(0, 4'b1000, 2'b01, 4'b0000);
    check_eq("mid_ack", 32'(obs_ack), 32'h8);
    check_eq("mid_assid", 32'(obs_assid[WID-1:0]), 32'h3);

    // Randomized traffic; retires mostly target CPUs with ops in flight.
    for (int n = 0; n < 1500; n++) begin
      r_req = NIN'($urandom);
      r_av  = NOUT'($urandom);
      r_ret = '0;
      for (int i = 0; i < NIN; i++) begin
        if (m_cnt[i] > 0 && $urandom_range(2) == 0) r_ret[i] = 1'b1;
        else if (m_cnt[i] == 0 && !r_req[i] && $urandom_range(99) == 0) r_ret[i] = 1'b1;
      end
      cycle(($urandom_range(63) == 0), r_req, r_av, r_ret);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
